// File: rtl/rtc_timer_prog.sv
// Settable time-of-day timer: clk is divided down to us/ms/s/min/hr/day counters
// with aligned one-cycle boundary pulses, run/pause, range-checked load and an hh:mm:ss alarm.
module rtc_timer_prog #(
    parameter int CLOCK_MHZ     = 200,
    parameter int HOURS_PER_DAY = 24,
    parameter int DAY_W         = 10,
    parameter int MS_PER_SEC    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             set_en,
    input  logic [DAY_W-1:0] set_day,
    input  logic [4:0]       set_hour,
    input  logic [5:0]       set_minute,
    input  logic [5:0]       set_second,
    input  logic             alarm_en,
    input  logic [4:0]       alarm_hour,
    input  logic [5:0]       alarm_minute,
    input  logic [5:0]       alarm_second,
    input  logic             alarm_clr,
    output logic [9:0]       usecond_cntr,
    output logic [9:0]       msecond_cntr,
    output logic [5:0]       second_cntr,
    output logic [5:0]       minute_cntr,
    output logic [4:0]       hour_cntr,
    output logic [DAY_W-1:0] day_cntr,
    output logic             usecond_pulse,
    output logic             msecond_pulse,
    output logic             second_pulse,
    output logic             minute_pulse,
    output logic             hour_pulse,
    output logic             day_pulse,
    output logic             set_err,
    output logic             alarm_pulse,
    output logic             alarm_flag
);

    localparam int                TICK_W    = (CLOCK_MHZ > 1) ? $clog2(CLOCK_MHZ) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLOCK_MHZ - 1);
    localparam logic [9:0]        US_LAST   = 10'd999;
    localparam logic [9:0]        MS_LAST   = 10'(MS_PER_SEC - 1);
    localparam logic [5:0]        SM_LAST   = 6'd59;
    localparam logic [4:0]        HR_LAST   = 5'(HOURS_PER_DAY - 1);
    localparam logic [5:0]        HR_MOD    = 6'(HOURS_PER_DAY);

    logic [TICK_W-1:0] r_tick;
    logic [9:0]        r_us;
    logic [9:0]        r_ms;
    logic [5:0]        r_sec;
    logic [5:0]        r_min;
    logic [4:0]        r_hr;
    logic [DAY_W-1:0]  r_day;
    logic [5:0]        r_pulse;
    logic              r_set_err;
    logic              r_alarm_pulse;
    logic              r_alarm_flag;

    // w_carry[k] is high on the edge that advances counter level k (0 = us .. 5 = day)
    logic [5:0]        w_carry;
    logic [5:0]        w_sec_next;
    logic [5:0]        w_min_next;
    logic [4:0]        w_hr_next;
    logic              w_alarm_hit;
    logic              w_hr_bad;
    logic              w_min_bad;
    logic              w_sec_bad;

    always_comb begin
        w_carry[0] = run && (r_tick == TICK_LAST);
        w_carry[1] = w_carry[0] && (r_us  == US_LAST);
        w_carry[2] = w_carry[1] && (r_ms  == MS_LAST);
        w_carry[3] = w_carry[2] && (r_sec == SM_LAST);
        w_carry[4] = w_carry[3] && (r_min == SM_LAST);
        w_carry[5] = w_carry[4] && (r_hr  == HR_LAST);
    end

    // Alarm compares against the time that becomes visible after this edge,
    // so the pulse lands in the same cycle as second_pulse.
    always_comb begin
        w_sec_next = w_carry[3] ? 6'd0 : (r_sec + 6'd1);
        w_min_next = r_min;
        if (w_carry[3]) begin
            w_min_next = w_carry[4] ? 6'd0 : (r_min + 6'd1);
        end
        w_hr_next = r_hr;
        if (w_carry[4]) begin
            w_hr_next = w_carry[5] ? 5'd0 : (r_hr + 5'd1);
        end
        w_alarm_hit = alarm_en && w_carry[2] && !set_en &&
                      (w_sec_next == alarm_second) &&
                      (w_min_next == alarm_minute) &&
                      (w_hr_next  == alarm_hour);
    end

    always_comb begin
        w_hr_bad  = {1'b0, set_hour} >= HR_MOD;
        w_min_bad = set_minute >= 6'd60;
        w_sec_bad = set_second >= 6'd60;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick        <= '0;
            r_us          <= '0;
            r_ms          <= '0;
            r_sec         <= '0;
            r_min         <= '0;
            r_hr          <= '0;
            r_day         <= '0;
            r_pulse       <= '0;
            r_set_err     <= 1'b0;
            r_alarm_pulse <= 1'b0;
        end else if (set_en) begin
            r_tick        <= '0;
            r_us          <= '0;
            r_ms          <= '0;
            r_sec         <= w_sec_bad ? 6'd0 : set_second;
            r_min         <= w_min_bad ? 6'd0 : set_minute;
            r_hr          <= w_hr_bad  ? 5'd0 : set_hour;
            r_day         <= set_day;
            r_pulse       <= '0;
            r_set_err     <= w_hr_bad || w_min_bad || w_sec_bad;
            r_alarm_pulse <= 1'b0;
        end else begin
            r_pulse       <= w_carry;
            r_set_err     <= 1'b0;
            r_alarm_pulse <= w_alarm_hit;
            if (run) begin
                r_tick <= w_carry[0] ? '0 : (r_tick + TICK_W'(1));
            end
            if (w_carry[0]) begin
                r_us <= w_carry[1] ? 10'd0 : (r_us + 10'd1);
            end
            if (w_carry[1]) begin
                r_ms <= w_carry[2] ? 10'd0 : (r_ms + 10'd1);
            end
            if (w_carry[2]) begin
                r_sec <= w_sec_next;
            end
            if (w_carry[3]) begin
                r_min <= w_min_next;
            end
            if (w_carry[4]) begin
                r_hr <= w_hr_next;
            end
            if (w_carry[5]) begin
                r_day <= r_day + DAY_W'(1);
            end
        end
    end

    // A hit on the same edge as alarm_clr leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alarm_flag <= 1'b0;
        end else if (w_alarm_hit) begin
            r_alarm_flag <= 1'b1;
        end else if (alarm_clr) begin
            r_alarm_flag <= 1'b0;
        end
    end

    assign usecond_cntr  = r_us;
    assign msecond_cntr  = r_ms;
    assign second_cntr   = r_sec;
    assign minute_cntr   = r_min;
    assign hour_cntr     = r_hr;
    assign day_cntr      = r_day;
    assign usecond_pulse = r_pulse[0];
    assign msecond_pulse = r_pulse[1];
    assign second_pulse  = r_pulse[2];
    assign minute_pulse  = r_pulse[3];
    assign hour_pulse    = r_pulse[4];
    assign day_pulse     = r_pulse[5];
    assign set_err       = r_set_err;
    assign alarm_pulse   = r_alarm_pulse;
    assign alarm_flag    = r_alarm_flag;

endmodule
